// File: rtl/conv_frame_gen_if.sv
// Byte-stream handshake into the frame generator and the bit/strobe pair
// it hands to the convolutional encoder.
interface conv_frame_gen_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       q_sig;
  logic       en_p;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready,
    input  q_sig,
    input  en_p
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready,
    output q_sig,
    output en_p
  );
endinterface

// File: rtl/conv_frame_gen.sv
// Frame bit source for the convolutional encoder: preamble, handshaked
// payload bytes and a zero tail, one bit per CLK_DIV-cycle period.
module conv_frame_gen #(
  parameter int unsigned CLK_DIV       = 8,
  parameter logic [15:0] PRE_PATTERN   = 16'hF0A5,
  parameter int unsigned PAYLOAD_BYTES = 4,
  parameter int unsigned TAIL_LEN      = 3
) (
  input  logic            clk_sig,
  input  logic            rst_n,
  input  logic            start,
  conv_frame_gen_if.slave bus,
  output logic            busy,
  output logic            frame_done
);
  localparam int unsigned DIV_W  = $clog2(CLK_DIV);
  localparam int unsigned TAIL_W = $clog2(TAIL_LEN + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [TAIL_W-1:0] TAIL_LAST = TAIL_W'(TAIL_LEN - 1);
  localparam logic [7:0]        BYTES     = 8'(PAYLOAD_BYTES);

  typedef enum logic [1:0] {IDLE, PRE, PAY, TAIL} state_t;

  state_t            state;
  logic [DIV_W-1:0]  div;
  logic [3:0]        pre_cnt;
  logic [2:0]        bit_cnt;
  logic [TAIL_W-1:0] tail_cnt;
  logic [7:0]        hold;
  logic              hold_full;
  logic [7:0]        shreg;
  logic [7:0]        byte_cnt;
  logic              stall;
  logic              q_reg;

  logic       ready;
  logic       take;
  logic       bit_end;
  logic       payload_done;
  logic       need_byte;
  logic       load;
  logic [7:0] next_byte;

  always_comb begin
    ready        = ((state == PRE) || (state == PAY)) && !hold_full && (byte_cnt < BYTES);
    take         = ready && bus.data_valid;
    bit_end      = (state != IDLE) && !stall && (div == DIV_LAST);
    payload_done = (byte_cnt == BYTES) && !hold_full;
    need_byte    = stall ||
                   (bit_end && (((state == PRE) && (pre_cnt == 4'd15)) ||
                                ((state == PAY) && (bit_cnt == 3'd7) && !payload_done)));
    // A byte arriving on the very edge it is needed bypasses the holding register.
    load         = need_byte && (hold_full || take);
    next_byte    = hold_full ? hold : bus.data_in;
  end

  assign bus.data_ready = ready;
  assign bus.en_p       = bit_end;
  assign bus.q_sig      = q_reg;

  always_ff @(posedge clk_sig or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      div        <= '0;
      pre_cnt    <= '0;
      bit_cnt    <= '0;
      tail_cnt   <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      shreg      <= '0;
      byte_cnt   <= '0;
      stall      <= 1'b0;
      q_reg      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (take) byte_cnt <= byte_cnt + 8'd1;
      if (take && !load) begin
        hold      <= bus.data_in;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state     <= PRE;
            busy      <= 1'b1;
            q_reg     <= PRE_PATTERN[15];
            div       <= '0;
            pre_cnt   <= '0;
            bit_cnt   <= '0;
            tail_cnt  <= '0;
            byte_cnt  <= '0;
            hold_full <= 1'b0;
            stall     <= 1'b0;
          end
        end
        default: begin
          if (load) begin
            state   <= PAY;
            shreg   <= next_byte;
            q_reg   <= next_byte[7];
            bit_cnt <= '0;
            div     <= '0;
            stall   <= 1'b0;
          end else if (need_byte) begin
            // Underrun: divider frozen, q_sig held, encoder not strobed.
            state <= PAY;
            stall <= 1'b1;
            div   <= '0;
          end else if (bit_end) begin
            div <= '0;
            if (state == PRE) begin
              pre_cnt <= pre_cnt + 4'd1;
              q_reg   <= PRE_PATTERN[4'd14 - pre_cnt];
            end else if (state == PAY) begin
              if (bit_cnt == 3'd7) begin
                state    <= TAIL;
                q_reg    <= 1'b0;
                tail_cnt <= '0;
              end else begin
                shreg   <= {shreg[6:0], shreg[7]};
                q_reg   <= shreg[6];
                bit_cnt <= bit_cnt + 3'd1;
              end
            end else begin
              q_reg <= 1'b0;
              if (tail_cnt == TAIL_LAST) begin
                state      <= IDLE;
                busy       <= 1'b0;
                frame_done <= 1'b1;
              end else begin
                tail_cnt <= tail_cnt + TAIL_W'(1);
              end
            end
          end else begin
            div <= div + DIV_W'(1);
          end
        end
      endcase
    end
  end
endmodule

// File: doc/conv_frame_gen.md
# conv_frame_gen

Upstream bit source for the convolutional encoder in the BPSK transmit chain. Builds one frame per `start` pulse: a fixed preamble, then a payload taken byte-wise over a valid/ready handshake, then a zero tail that flushes the encoder memory. Bits come out one at a time on `q_sig`, each qualified by a one-cycle `en_p` strobe at a programmable bit rate. The outputs drive the encoder's `q_sig`/`en_p` inputs directly.

## Interface
- `CLK_DIV`, default 8: clock cycles per bit period; minimum 2.
- `PRE_PATTERN`, default 16'hF0A5: 16-bit preamble, sent MSB first.
- `PAYLOAD_BYTES`, default 4: bytes per frame; range 1–255.
- `TAIL_LEN`, default 3: zero bits appended; 3 = encoder memory (K−1).
- `clk_sig`, input, 1: the single clock; all logic on its rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `start`, input, 1: one-cycle frame request; ignored unless IDLE.
- `data_in`, input, 8: payload byte.
- `data_valid`, input, 1: `data_in` is valid.
- `data_ready`, output, 1: the block can accept a byte this cycle.
- `q_sig`, output, 1: current frame bit.
- `en_p`, output, 1: one-cycle strobe; the encoder samples `q_sig` on this cycle.
- `busy`, output, 1: a frame is in progress.
- `frame_done`, output, 1: one-cycle pulse at the end of a frame.

## Operation
- States: IDLE → PRE → PAY → TAIL → IDLE.
- Reset (asynchronous, `rst_n`=0):
  - state returns to IDLE;
  - every output is 0;
  - the divider, the bit counters, the holding register and the byte counter are cleared.
- IDLE → PRE: `start`=1 at a clock edge.
- Bit generation:
  - Each bit is loaded onto `q_sig` at the start of its bit period and held for `CLK_DIV` cycles.
  - `en_p`=1 only in the last cycle of the period (divider == `CLK_DIV`−1).
  - The next bit loads on the edge that ends the `en_p` cycle.
- PRE: 16 bits of `PRE_PATTERN`, MSB first, then PAY.
- PAY:
  - `PAYLOAD_BYTES`×8 bits, each byte MSB first, then TAIL.
  - Each byte comes from a one-byte holding register, which is moved into an 8-bit shift register when the shift register needs a byte.
- TAIL: `TAIL_LEN` bits with `q_sig`=0, then IDLE.
- Handshake:
  - `data_ready` = (state is PRE or PAY) AND holding register empty AND bytes accepted < `PAYLOAD_BYTES`.
  - A byte is transferred on any edge where `data_valid`=1 and `data_ready`=1.
  - `data_ready` is a registered/combinational function of state only; it never depends on `data_valid`.
- Underrun:
  - Condition: a payload bit period is due to start and no byte is available.
  - The divider freezes and `en_p` stays 0.
  - `q_sig` holds its previous value.
  - Generation resumes with a full `CLK_DIV` period once a byte is loaded.
  - The encoder does not advance during the stall; no bits are lost or duplicated.
- `busy`: 1 in PRE, PAY and TAIL; 0 in IDLE.
- `frame_done`: 1 in the first IDLE cycle after the last tail `en_p`.
- Counter widths:
  - divider: $clog2(`CLK_DIV`) bits;
  - bit counter: 4 bits (preamble), 3 bits (within a byte), $clog2(`TAIL_LEN`+1) bits (tail);
  - byte counter: 8 bits.
- `start` while busy: no effect, including no restart and no extra frame queued.

## Timing
- `start` is sampled at edge 0.
  - From cycle 1: `busy`=1, `q_sig`=`PRE_PATTERN`[15].
  - The first `en_p` is in cycle `CLK_DIV`.
- Without stalls:
  - `en_p` strobes are exactly `CLK_DIV` cycles apart.
  - Strobes per frame = 16 + 8×`PAYLOAD_BYTES` + `TAIL_LEN`; the default is 51.
- Last strobe in cycle N → `frame_done`=1 and `busy`=0 in cycle N+1; `start` is accepted again from cycle N+1.
- A byte accepted at any time up to and including the edge ending the previous byte's last `en_p` cycle causes no stall.
- Asserting reset mid-frame takes effect immediately (asynchronous). No `frame_done` is produced. After release the block waits in IDLE for a new `start`.

## Test plan
- Default parameters, `data_valid` held at 1 with bytes 8'h12, 8'h34, 8'h56, 8'h78:
  - exactly 51 `en_p`, 8 cycles apart;
  - sampled bits = F0A5, then 12345678, then 000;
  - one `frame_done` pulse, 1 cycle after the 51st `en_p`.
- Underrun: withhold byte 3 for 40 cycles after `data_ready` rises:
  - no `en_p` and `q_sig` stable during the gap;
  - total strobe count is still 51;
  - bit sequence unchanged.
- `start` pulsed in PRE and again in TAIL:
  - no change in sequence or timing;
  - only one `frame_done`.
- `rst_n` pulsed low mid-PAY (after byte 2 is accepted):
  - all outputs 0 in the same cycle;
  - no `frame_done`;
  - the next `start` yields a full clean 51-bit frame.
- `CLK_DIV`=2, `PAYLOAD_BYTES`=1, byte 8'hC3:
  - 27 `en_p` on every second cycle;
  - bits = F0A5, then C3, then 000.
- `data_valid`=1 while IDLE: `data_ready`=0 and no byte is consumed.
